// File: rtl/norm_divider.sv
// Unsigned 32/32 divider: align divisor to the dividend, then restoring shift-subtract.
// Latency 2k+2 cycles (k = alignment shifts), 1 cycle for divide by zero; no backpressure, divrst restarts at any time.
// Result held with divdone high until the next divrst.
module norm_divider (
    input  logic        clk,
    input  logic        divrst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic [31:0] alb,
    output logic        divdone
);

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_DIV   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] sb_q, sb_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [31:0] sb_shl;
    logic        can_shift;
    logic        rem_ge;

    assign sb_shl    = {sb_q[30:0], 1'b0};
    assign can_shift = !sb_q[31] && (sb_shl <= a_q);
    assign rem_ge    = (rem_q >= sb_q);

    always_ff @(posedge clk) begin
        if (divrst) begin
            state_q <= ST_ALIGN;
            a_q     <= a;
            sb_q    <= b;
            rem_q   <= a;
            quo_q   <= 32'd0;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sb_q    <= sb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ALIGN: begin
                if (sb_q == 32'd0) begin
                    state_d = ST_DONE;
                end else if (!can_shift) begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        sb_d  = sb_q;
        rem_d = rem_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_ALIGN: begin
                // Zero divisor: all-ones quotient, dividend as remainder.
                if (sb_q == 32'd0) begin
                    quo_d = 32'hFFFF_FFFF;
                    rem_d = a_q;
                end else if (can_shift) begin
                    sb_d  = sb_shl;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DIV: begin
                if (rem_ge) begin
                    rem_d = rem_q - sb_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    quo_d = {quo_q[30:0], 1'b0};
                end
                sb_d = {1'b0, sb_q[31:1]};
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        divdone = (state_q == ST_DONE);
        q       = divdone ? quo_q : 32'd0;
        r       = divdone ? rem_q : 32'd0;
        alb     = sb_q;
    end

endmodule

// File: tb/tb_norm_divider.sv
// Directed and randomized checks of norm_divider results, latency, abort and hold behaviour.
module tb_norm_divider;

    logic        clk = 1'b0;
    logic        divrst = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] q, r, alb;
    logic        divdone;

    int tests = 0;
    int fails = 0;

    norm_divider dut (
        .clk     (clk),
        .divrst  (divrst),
        .a       (a),
        .b       (b),
        .q       (q),
        .r       (r),
        .alb     (alb),
        .divdone (divdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold divrst for 'hold' edges; outputs are checked just after the last one.
    task automatic start(input logic [31:0] av, input logic [31:0] bv, input int hold, input bit scramble);
        @(negedge clk);
        a      = av;
        b      = bv;
        divrst = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        divrst = 1'b0;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_alb", alb, bv);
        check("rst_done", divdone, 0);
        if (scramble) begin
            a = $urandom;
            b = $urandom;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            if (divdone) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input int hold,
                           input logic [31:0] eq, input logic [31:0] er, input int elat, input string tag);
        int lat;
        start(av, bv, hold, 1'b1);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
    endtask

    initial begin
        int lat;
        logic [31:0] alb_exp [8];

        // 100 / 7: k=3, stepwise alb trace
        alb_exp = '{32'd14, 32'd28, 32'd56, 32'd56, 32'd28, 32'd14, 32'd7, 32'd3};
        start(32'd100, 32'd7, 1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("d7_alb%0d", c + 1), alb, alb_exp[c]);
            check($sformatf("d7_done%0d", c + 1), divdone, (c == 7) ? 1 : 0);
            if (c < 7) check($sformatf("d7_qbusy%0d", c + 1), q, 0);
        end
        check("d7_q", q, 32'd14);
        check("d7_r", r, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("d7_hold_done", divdone, 1);
        check("d7_hold_q", q, 32'd14);
        check("d7_hold_r", r, 32'd2);

        run_div(32'd5, 32'd10, 1, 32'd0, 32'd5, 2, "small");
        run_div(32'h8000_0000, 32'h8000_0000, 1, 32'd1, 32'd0, 2, "msb");
        run_div(32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 64, "max");
        run_div(32'd1234, 32'd0, 1, 32'hFFFF_FFFF, 32'd1234, 1, "dz");
        run_div(32'd50, 32'd7, 4, 32'd7, 32'd1, 6, "hold");

        // Abort: second divrst at edge 5 replaces a 1000/3 run
        start(32'd1000, 32'd3, 1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_done%0d", c), divdone, 0);
        end
        start(32'd50, 32'd7, 1, 1'b1);
        wait_done(lat);
        check("abort_lat", lat, 6);
        check("abort_q", q, 32'd7);
        check("abort_r", r, 32'd1);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] av, bv;
            int k;
            av = $urandom >> $urandom_range(0, 8);
            bv = $urandom >> $urandom_range(0, 31);
            if (bv == 32'd0) bv = 32'd1;
            k = 0;
            while ((64'(bv) << (k + 1)) <= 64'(av)) k++;
            run_div(av, bv, 1, av / bv, av % bv, 2 * k + 2, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/norm_divider.md
# norm_divider

Unsigned 32-bit sequential divider combining a divisor-alignment stage and a restoring shift-subtract stage. It sits under the CPU's multiply/divide unit, which handles operand and result sign conversion for signed DIV. This block sees only magnitudes and returns unsigned quotient and remainder.

## Interface
- No parameters; the datapath width is fixed at 32.
- clk  in  1  sole clock; all state updates on rising edge.
- divrst  in  1  synchronous, active-high reset/start; sampling it high (re)starts a division.
- a  in  32  dividend; captured when divrst is sampled high.
- b  in  32  divisor; captured when divrst is sampled high.
- q  out  32  quotient; valid while done=1.
- r  out  32  remainder; valid while done=1.
- alb  out  32  current shifted divisor register (debug/observability).
- divdone  out  1  high when the result is valid; held until the next divrst.

## Operation
- Internal registers: A (dividend copy), SB (shifted divisor), REM, Q, CNT (6 bits), and state in {ALIGN, DIV, DONE}.
- Reset/start (divrst=1 at an edge) performs the following updates:
  - A←a, REM←a, SB←b, Q←0, CNT←0, state←ALIGN.
  - Outputs after that edge: q=0, r=0, alb=b, divdone=0.
  - divrst has priority over all other activity.
- ALIGN, one decision per edge:
  - b==0 (SB==0): go directly to DONE with Q←32'hFFFFFFFF and REM←A.
  - Else if SB[31]==0 and (SB<<1) ≤ A: SB←SB<<1, CNT←CNT+1, stay in ALIGN.
  - Else: go to DIV with no shift on that edge.
  - Final SB = b·2^k, with k the largest value keeping SB ≤ A and no overflow. k=0 when b > A.
- DIV, one quotient bit per edge:
  - If REM ≥ SB: REM←REM−SB and Q←{Q[30:0],1}. Else Q←{Q[30:0],0}.
  - SB←SB>>1.
  - If CNT==0, go to DONE. Else CNT←CNT−1.
  - Exactly k+1 iterations are performed.
- DONE:
  - q=Q, r=REM, divdone=1.
  - All registers hold until the next divrst.
- q and r outputs read 0 in ALIGN/DIV and show Q/REM only in DONE. alb always shows SB.
- Invariant at DONE for b≠0: q·b + r = a, with r < b.
- Power-up state is undefined. The first division requires a divrst pulse.

## Timing
- Edge 0 is the edge that samples divrst=1.
- ALIGN occupies edges 1..k+1, and DIV occupies edges k+2..2k+2.
- divdone rises after edge 2k+2, a latency of 2k+2 cycles.
- Minimum latency is 2 cycles (b > a). Maximum is 64 cycles (k=31, e.g. b=1, a≥2^31).
- Divide by zero completes after edge 1 (latency 1).
- divrst held high for several cycles keeps the block in the reset state. Counting starts from the last edge with divrst high.
- divrst mid-operation (ALIGN or DIV) aborts immediately:
  - New operands are loaded and divdone stays 0.
  - No partial result is ever flagged valid.
- a and b may change freely after edge 0 without affecting the result.

## Test plan
- a=100, b=7, divrst one cycle: alb steps 7,14,28,56 (k=3), then 28,14,7,3. divdone=1 exactly 8 cycles after edge 0 with q=14, r=2.
- a=5, b=10: k=0, divdone after 2 cycles, q=0, r=5. a=b=32'h80000000: divdone after 2 cycles, q=1, r=0.
- a=32'hFFFFFFFF, b=1: k=31, divdone after 64 cycles, q=32'hFFFFFFFF, r=0. Confirm divdone is 0 at cycle 63.
- a=1234, b=0: divdone after 1 cycle, q=32'hFFFFFFFF, r=1234.
- Start a=1000, b=3, then assert divrst at cycle 5 with a=50, b=7:
  - divdone never rises for the first operation.
  - Final result is q=7, r=1, 6 cycles (k=2) after the second divrst.
- Randomized a, b≠0 (≥1000 cases): q·b+r==a, r<b, and latency equals 2k+2 with k = floor(log2(a/b)) (k=0 when b>a). Inputs are changed randomly after edge 0 to confirm capture.
